// File: rtl/teclado_pkg.sv
// Shared types and defaults for the keypad scanner.
// Holds the scanner state enum and the row-pattern helpers.
package teclado_pkg;

  localparam int SCAN_CYCLES_DEF     = 1000;
  localparam int DEBOUNCE_CYCLES_DEF = 10000;

  localparam logic [3:0] FILAS_REPOSO = 4'b1111;

  typedef enum logic [1:0] {
    ESCANEO    = 2'd0,
    VALIDANDO  = 2'd1,
    PRESIONADA = 2'd2,
    LIBERANDO  = 2'd3
  } estado_t;

  // True when exactly one row is pulled low.
  function automatic logic una_fila_baja(input logic [3:0] filas);
    return (filas == 4'b1110) || (filas == 4'b1101) ||
           (filas == 4'b1011) || (filas == 4'b0111);
  endfunction

  function automatic logic [1:0] indice_fila(input logic [3:0] filas);
    logic [1:0] idx;
    idx = 2'd0;
    case (filas)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/barrido_teclado_if.sv
// Keypad-side bundle: raw rows in, column drive and key-event outputs.
// master = scanner, slave = the board/receiver side.
interface teclado_if;
  logic [3:0] filas;
  logic [3:0] columnas;
  logic [1:0] cuenta;
  logic [3:0] pulso_teclas;
  logic       tecla_presionada;
  logic [3:0] dato;

  modport master (
    input  filas,
    output columnas, cuenta, pulso_teclas, tecla_presionada, dato
  );

  modport slave (
    output filas,
    input  columnas, cuenta, pulso_teclas, tecla_presionada, dato
  );
endinterface

// File: rtl/barrido_teclado_sincronizador.sv
// Multi-stage flop synchronizer for asynchronous inputs.
// Resets to all-ones so idle pulled-up rows read as "no key".
module sincronizador #(
  parameter int ANCHO  = 4,
  parameter int ETAPAS = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [ANCHO-1:0] d_i,
  output logic [ANCHO-1:0] q_o
);

  logic [ETAPAS-1:0][ANCHO-1:0] etapas_q, etapas_d;

  always_comb begin
    etapas_d    = etapas_q;
    etapas_d[0] = d_i;
    for (int i = 1; i < ETAPAS; i++) etapas_d[i] = etapas_q[i-1];
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) etapas_q <= '1;
    else          etapas_q <= etapas_d;
  end

  assign q_o = etapas_q[ETAPAS-1];

endmodule

// File: rtl/barrido_teclado.sv
// 4x4 keypad column scanner with press/release debounce.
// state      | meaning
// ESCANEO    | driving columns in turn, sampling rows at end of each slot
// VALIDANDO  | single key seen, counting stable cycles before accepting
// PRESIONADA | key accepted, column frozen, waiting for all rows high
// LIBERANDO  | rows high, counting stable cycles before re-arming
module barrido_teclado
  import teclado_pkg::*;
#(
  parameter int SCAN_CYCLES     = SCAN_CYCLES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [3:0] filas_i,
  output logic [3:0] columnas_o,
  output logic [1:0] cuenta_o,
  output logic [3:0] pulso_teclas_o,
  output logic       tecla_presionada_o,
  output logic [3:0] dato_o
);

  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [SW-1:0] SLOT_ULT = SW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DEB_ULT  = DW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    filas_s;
  estado_t       estado_q, estado_d;
  logic [1:0]    cuenta_q, cuenta_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [3:0]    patron_q, patron_d;
  logic [3:0]    pulso_q, pulso_d;
  logic          tecla_q, tecla_d;
  logic [3:0]    dato_q, dato_d;

  sincronizador #(.ANCHO(4), .ETAPAS(2)) u_sinc (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (filas_i),
    .q_o     (filas_s)
  );

  always_comb begin
    estado_d = estado_q;
    cuenta_d = cuenta_q;
    slot_d   = slot_q;
    deb_d    = deb_q;
    patron_d = patron_q;
    pulso_d  = '0;
    tecla_d  = tecla_q;
    dato_d   = dato_q;
    case (estado_q)
      ESCANEO: begin
        if (slot_q == SLOT_ULT) begin
          slot_d = '0;
          if (filas_s == FILAS_REPOSO) begin
            cuenta_d = cuenta_q + 2'd1;
          end else begin
            patron_d = filas_s;
            deb_d    = '0;
            estado_d = VALIDANDO;
          end
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      VALIDANDO: begin
        if ((filas_s == patron_q) && una_fila_baja(filas_s)) begin
          deb_d = deb_q + 1'b1;
          // Accept on the Nth matching cycle so the pulse lands N cycles after entry.
          if (deb_q == DEB_ULT) begin
            estado_d = PRESIONADA;
            pulso_d  = ~filas_s;
            dato_d   = {indice_fila(filas_s), cuenta_q};
            tecla_d  = 1'b1;
          end
        end else begin
          estado_d = ESCANEO;
          cuenta_d = cuenta_q + 2'd1;
          slot_d   = '0;
        end
      end
      PRESIONADA: begin
        if (filas_s == FILAS_REPOSO) begin
          deb_d    = '0;
          estado_d = LIBERANDO;
        end
      end
      LIBERANDO: begin
        if (filas_s == FILAS_REPOSO) begin
          deb_d = deb_q + 1'b1;
          if (deb_q == DEB_ULT) begin
            estado_d = ESCANEO;
            tecla_d  = 1'b0;
            cuenta_d = cuenta_q + 2'd1;
            slot_d   = '0;
            deb_d    = '0;
          end
        end else begin
          estado_d = PRESIONADA;
        end
      end
      default: estado_d = ESCANEO;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      estado_q <= ESCANEO;
      cuenta_q <= '0;
      slot_q   <= '0;
      deb_q    <= '0;
      patron_q <= FILAS_REPOSO;
      pulso_q  <= '0;
      tecla_q  <= 1'b0;
      dato_q   <= '0;
    end else begin
      estado_q <= estado_d;
      cuenta_q <= cuenta_d;
      slot_q   <= slot_d;
      deb_q    <= deb_d;
      patron_q <= patron_d;
      pulso_q  <= pulso_d;
      tecla_q  <= tecla_d;
      dato_q   <= dato_d;
    end
  end

  assign columnas_o         = ~(4'b0001 << cuenta_q);
  assign cuenta_o           = cuenta_q;
  assign pulso_teclas_o     = pulso_q;
  assign tecla_presionada_o = tecla_q;
  assign dato_o             = dato_q;

endmodule
